phy_rx_frame_decode: RTL and testbench

Downstream stage of the PHY receive sampler, in the clk_40mhz domain. It consumes 8-sample chunks of the oversampled RX line (4 samples per bit, 2 bits per chunk) and recovers the bit phase from line edges. It deframes UART-style serial frames (start 0, DATA_BITS data bits LSB first, stop 1) and delivers each received byte to the MAC/link layer with a one-cycle valid pulse. It also flags framing errors.

---
 rtl/phy_rx_frame_decode.sv | 153 +++++++++++++++
 tb/tb_phy_rx_frame_decode.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_frame_decode.sv
// Recovers bit phase from an oversampled RX line (4 samples/bit, 8 samples per strobe)
// and deframes start/data/stop serial frames into bytes with valid and framing-error pulses.
module phy_rx_frame_decode #(
  parameter int DATA_BITS = 8,
  parameter bit RESYNC_EN = 1'b1
) (
  input  logic       clk_40mhz,
  input  logic       reset_n,
  input  logic       in_ready,
  input  logic [7:0] RX_sampled,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] phase_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_BREAK} state_t;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [1:0] r_phase;
  logic       r_last;

  logic [8:0] w_s;
  logic [3:0] w_edge_k;
  logic       w_edge_found;
  logic [3:0] w_idx0;
  logic [3:0] w_idx1;
  logic       w_b0;
  logic       w_b1;
  state_t     w_state_mid;
  state_t     w_state_nxt;
  logic [3:0] w_cnt_mid;
  logic [3:0] w_cnt_nxt;
  logic [7:0] w_sh_mid;
  logic [7:0] w_sh_nxt;
  logic       w_vld0;
  logic       w_vld1;
  logic       w_err0;
  logic       w_err1;

  // One bit through the frame FSM; called twice per strobe so b0 and b1 chain.
  function automatic void frame_step(
    input  state_t     st,
    input  logic [3:0] cnt,
    input  logic [7:0] sh,
    input  logic       b,
    output state_t     st_n,
    output logic [3:0] cnt_n,
    output logic [7:0] sh_n,
    output logic       vld,
    output logic       err
  );
    st_n  = st;
    cnt_n = cnt;
    sh_n  = sh;
    vld   = 1'b0;
    err   = 1'b0;
    case (st)
      S_IDLE: begin
        if (!b) begin
          st_n  = S_DATA;
          cnt_n = 4'd0;
          sh_n  = 8'd0;
        end
      end
      S_DATA: begin
        sh_n[cnt[2:0]] = b;
        cnt_n = cnt + 4'd1;
        if (cnt_n == 4'(DATA_BITS)) st_n = S_STOP;
      end
      S_STOP: begin
        if (b) begin
          vld  = 1'b1;
          st_n = S_IDLE;
        end else begin
          err  = 1'b1;
          st_n = S_BREAK;
        end
      end
      default: begin
        if (b) st_n = S_IDLE;
      end
    endcase
  endfunction

  always_comb begin
    w_s[0] = r_last;
    for (int i = 1; i <= 8; i++) w_s[i] = RX_sampled[8-i];
  end

  // Descending scan so the lowest edge index wins.
  always_comb begin
    w_edge_k     = 4'd0;
    w_edge_found = 1'b0;
    for (int k = 8; k >= 1; k--) begin
      if (w_s[k] != w_s[k-1]) begin
        w_edge_k     = 4'(k);
        w_edge_found = 1'b1;
      end
    end
  end

  assign w_idx0 = {2'b00, r_phase} + 4'd1;
  assign w_idx1 = {2'b00, r_phase} + 4'd5;
  assign w_b0   = w_s[w_idx0];
  assign w_b1   = w_s[w_idx1];

  always_comb begin
    frame_step(r_state, r_bit_cnt, r_shift, w_b0,
               w_state_mid, w_cnt_mid, w_sh_mid, w_vld0, w_err0);
    frame_step(w_state_mid, w_cnt_mid, w_sh_mid, w_b1,
               w_state_nxt, w_cnt_nxt, w_sh_nxt, w_vld1, w_err1);
  end

  always_ff @(posedge clk_40mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_phase    <= 2'd2;
      r_last     <= 1'b1;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (in_ready) begin
        r_last    <= w_s[8];
        r_state   <= w_state_nxt;
        r_bit_cnt <= w_cnt_nxt;
        r_shift   <= w_sh_nxt;
        busy      <= (w_state_nxt == S_DATA) || (w_state_nxt == S_STOP);
        if (w_edge_found && (RESYNC_EN || r_state == S_IDLE))
          r_phase <= w_edge_k[1:0] + 2'd1;
        // A stop bit only passes through STOP, which leaves the shift intact,
        // so the mid-strobe shift holds the byte whichever bit completed it.
        if (w_vld0 || w_vld1) begin
          data_out   <= w_sh_mid;
          data_valid <= 1'b1;
        end
        frame_err <= w_err0 | w_err1;
      end
    end
  end

  assign phase_dbg = r_phase;

endmodule

// File: tb/tb_phy_rx_frame_decode.sv
// Directed bench for phy_rx_frame_decode: default instance plus a 7-bit, no-resync instance.
module tb_phy_rx_frame_decode;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       strobe;
  logic       sel;
  logic [7:0] rx;
  logic       in_ready_a;
  logic       in_ready_b;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b, err_a, err_b, busy_a, busy_b;
  logic [1:0] phase_a, phase_b;

  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int         err_cnt_a = 0;
  int         err_cnt_b = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #12 clk = ~clk;

  assign in_ready_a = strobe & ~sel;
  assign in_ready_b = strobe & sel;

  phy_rx_frame_decode u_dut (
    .clk_40mhz(clk), .reset_n(reset_n), .in_ready(in_ready_a), .RX_sampled(rx),
    .data_out(dout_a), .data_valid(valid_a), .frame_err(err_a), .busy(busy_a),
    .phase_dbg(phase_a)
  );

  phy_rx_frame_decode #(.DATA_BITS(7), .RESYNC_EN(1'b0)) u_dut7 (
    .clk_40mhz(clk), .reset_n(reset_n), .in_ready(in_ready_b), .RX_sampled(rx),
    .data_out(dout_b), .data_valid(valid_b), .frame_err(err_b), .busy(busy_b),
    .phase_dbg(phase_b)
  );

  // Pulse capture: every data_valid cycle records data_out, every frame_err cycle counts.
  always @(negedge clk) begin
    if (valid_a) cap_a.push_back(dout_a);
    if (err_a) err_cnt_a++;
    if (valid_b) cap_b.push_back(dout_b);
    if (err_b) err_cnt_b++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_chunk(input logic [7:0] c, input int gap);
    @(posedge clk);
    #2;
    rx     = c;
    strobe = 1'b1;
    @(posedge clk);
    #2;
    strobe = 1'b0;
    repeat (gap) @(posedge clk);
    #2;
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_b.delete();
    err_cnt_a = 0;
    err_cnt_b = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    strobe  = 1'b0;
    sel     = 1'b0;
    rx      = 8'hFF;
    idle(3);
    n_cmp++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h exp 00", dout_a); end
    n_cmp++; if ({valid_a, err_a, busy_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {valid_a, err_a, busy_a}); end
    n_cmp++; if (phase_a !== 2'd2) begin n_fail++; $display("FAIL reset_phase got %0d exp 2", phase_a); end
    n_cmp++; if ({dout_b, valid_b, err_b, busy_b, phase_b} !== {8'h00, 3'b000, 2'd2}) begin n_fail++; $display("FAIL reset_dut7 got %h exp 002", {dout_b, valid_b, err_b, busy_b, phase_b}); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame();
    clear_caps();
    for (int i = 0; i < 3; i++) send_chunk(8'hFF, 0);
    send_chunk(8'h0F, 0);
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid got %b exp 1", busy_a); end
    for (int i = 0; i < 4; i++) send_chunk(8'h0F, 0);
    send_chunk(8'hFF, 0);
    idle(3);
    n_cmp++; if (cap_a.size() !== 1) begin n_fail++; $display("FAIL basic_valid_count got %0d exp 1", cap_a.size()); end
    n_cmp++; if (cap_a.size() > 0 && cap_a[0] !== 8'h55) begin n_fail++; $display("FAIL basic_data got %h exp 55", cap_a[0]); end
    n_cmp++; if (err_cnt_a !== 0) begin n_fail++; $display("FAIL basic_err_count got %0d exp 0", err_cnt_a); end
    n_cmp++; if (phase_a !== 2'd2) begin n_fail++; $display("FAIL basic_phase got %0d exp 2", phase_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", busy_a); end
    n_cmp++; if (dout_a !== 8'h55) begin n_fail++; $display("FAIL basic_data_held got %h exp 55", dout_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [10];
    v = '{8'h0F, 8'hF0, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h0F, 8'hFF, 8'hF0, 8'h0F};
    clear_caps();
    for (int i = 0; i < 10; i++) send_chunk(v[i], 1);
    send_chunk(8'hFF, 1);
    idle(3);
    n_cmp++; if (cap_a.size() !== 2) begin n_fail++; $display("FAIL b2b_valid_count got %0d exp 2", cap_a.size()); end
    n_cmp++; if (cap_a.size() > 0 && cap_a[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_first got %h exp a3", cap_a[0]); end
    n_cmp++; if (cap_a.size() > 1 && cap_a[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_second got %h exp 3c", cap_a[1]); end
    n_cmp++; if (err_cnt_a !== 0) begin n_fail++; $display("FAIL b2b_err_count got %0d exp 0", err_cnt_a); end
  endtask

  task automatic test_phase_shift();
    clear_caps();
    send_chunk(8'hFF, 0);
    send_chunk(8'h87, 0);
    n_cmp++; if (phase_a !== 2'd3) begin n_fail++; $display("FAIL shift_phase got %0d exp 3", phase_a); end
    for (int i = 0; i < 4; i++) send_chunk(8'h87, 0);
    send_chunk(8'hFF, 0);
    idle(3);
    n_cmp++; if (cap_a.size() !== 1) begin n_fail++; $display("FAIL shift_valid_count got %0d exp 1", cap_a.size()); end
    n_cmp++; if (cap_a.size() > 0 && cap_a[0] !== 8'h55) begin n_fail++; $display("FAIL shift_data got %h exp 55", cap_a[0]); end
    n_cmp++; if (phase_a !== 2'd3) begin n_fail++; $display("FAIL shift_phase_end got %0d exp 3", phase_a); end
  endtask

  task automatic test_framing_error();
    logic [7:0] bad [5];
    logic [7:0] good [5];
    bad  = '{8'h00, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    good = '{8'h00, 8'hF0, 8'h0F, 8'h00, 8'h0F};
    send_chunk(8'hFF, 0);
    clear_caps();
    for (int i = 0; i < 5; i++) send_chunk(bad[i], 0);
    for (int i = 0; i < 3; i++) send_chunk(8'h00, 0);
    idle(2);
    n_cmp++; if (err_cnt_a !== 1) begin n_fail++; $display("FAIL ferr_err_count got %0d exp 1", err_cnt_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_break got %b exp 0", busy_a); end
    n_cmp++; if (dout_a !== 8'h55) begin n_fail++; $display("FAIL ferr_data_kept got %h exp 55", dout_a); end
    send_chunk(8'hFF, 0);
    for (int i = 0; i < 5; i++) send_chunk(good[i], 0);
    send_chunk(8'hFF, 0);
    idle(3);
    n_cmp++; if (cap_a.size() !== 1) begin n_fail++; $display("FAIL ferr_valid_count got %0d exp 1", cap_a.size()); end
    n_cmp++; if (cap_a.size() > 0 && cap_a[0] !== 8'h12) begin n_fail++; $display("FAIL ferr_next_data got %h exp 12", cap_a[0]); end
    n_cmp++; if (err_cnt_a !== 1) begin n_fail++; $display("FAIL ferr_err_total got %0d exp 1", err_cnt_a); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f [5];
    f = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'hFF};
    clear_caps();
    send_chunk(8'hFF, 0);
    send_chunk(8'h0F, 0);
    send_chunk(8'hF0, 0);
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got %b exp 1", busy_a); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({dout_a, valid_a, err_a, busy_a} !== 11'h000) begin n_fail++; $display("FAIL rst_outputs got %h exp 000", {dout_a, valid_a, err_a, busy_a}); end
    n_cmp++; if (phase_a !== 2'd2) begin n_fail++; $display("FAIL rst_phase got %0d exp 2", phase_a); end
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send_chunk(8'hFF, 0);
    for (int i = 0; i < 5; i++) send_chunk(f[i], 0);
    send_chunk(8'hFF, 0);
    idle(3);
    n_cmp++; if (cap_a.size() !== 1) begin n_fail++; $display("FAIL rst_valid_count got %0d exp 1", cap_a.size()); end
    n_cmp++; if (cap_a.size() > 0 && cap_a[0] !== 8'h81) begin n_fail++; $display("FAIL rst_next_data got %h exp 81", cap_a[0]); end
  endtask

  task automatic test_seven_bit_gaps();
    logic [7:0] f [5];
    f = '{8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sel = 1'b1;
    clear_caps();
    send_chunk(8'hFF, 3);
    send_chunk(f[0], 3);
    send_chunk(f[1], 3);
    n_cmp++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL seven_busy_gap got %b exp 1", busy_b); end
    for (int i = 2; i < 5; i++) send_chunk(f[i], 3);
    send_chunk(8'hFF, 3);
    idle(2);
    n_cmp++; if (cap_b.size() !== 1) begin n_fail++; $display("FAIL seven_valid_count got %0d exp 1", cap_b.size()); end
    n_cmp++; if (cap_b.size() > 0 && cap_b[0] !== 8'h7F) begin n_fail++; $display("FAIL seven_data got %h exp 7f", cap_b[0]); end
    n_cmp++; if (cap_a.size() !== 0) begin n_fail++; $display("FAIL seven_other_idle got %0d exp 0", cap_a.size()); end
    clear_caps();
    send_chunk(8'h00, 3);
    send_chunk(8'h00, 3);
    send_chunk(8'h00, 3);
    send_chunk(8'h07, 3);
    n_cmp++; if (phase_b !== 2'd2) begin n_fail++; $display("FAIL seven_no_resync got %0d exp 2", phase_b); end
    send_chunk(8'hFF, 3);
    send_chunk(8'hFF, 3);
    idle(2);
    n_cmp++; if (cap_b.size() !== 1) begin n_fail++; $display("FAIL seven_valid2_count got %0d exp 1", cap_b.size()); end
    n_cmp++; if (cap_b.size() > 0 && cap_b[0] !== 8'h40) begin n_fail++; $display("FAIL seven_data2 got %h exp 40", cap_b[0]); end
    n_cmp++; if (err_cnt_b !== 0) begin n_fail++; $display("FAIL seven_err_count got %0d exp 0", err_cnt_b); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_phase_shift();
    test_framing_error();
    test_reset_mid_frame();
    test_seven_bit_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
